gcd_unit: RTL

GCD_UNIT -- requirements
Module: gcd_unit

---
 rtl/gcd_pkg.sv | 12 +
 rtl/gcd_datapath.sv | 67 ++++++
 rtl/gcd_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD unit.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, subtraction counter and the magnitude compares that steer the GCD FSM.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             sub_a_i,
    input  logic             sub_b_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] iter_o,
    output logic             gt_o,
    output logic             lt_o,
    output logic             eq_o,
    output logic             a_zero_o,
    output logic             b_zero_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] iter_q, iter_d;

    // The FSM only strobes a subtract when the compare says it cannot underflow.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        iter_d = iter_q;
        if (load_i) begin
            a_d    = a_i;
            b_d    = b_i;
            iter_d = '0;
        end else if (sub_a_i) begin
            a_d    = a_q - b_q;
            iter_d = iter_q + 1'b1;
        end else if (sub_b_i) begin
            b_d    = b_q - a_q;
            iter_d = iter_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            iter_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            iter_q <= iter_d;
        end
    end

    assign a_o      = a_q;
    assign b_o      = b_q;
    assign iter_o   = iter_q;
    assign gt_o     = (a_q > b_q);
    assign lt_o     = (a_q < b_q);
    assign eq_o     = (a_q == b_q);
    assign a_zero_o = (a_q == '0);
    assign b_zero_o = (b_q == '0);

endmodule

// File: rtl/gcd_unit.sv
// Subtractive (Euclid) GCD engine: a three-state controller driving gcd_datapath.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] iter,
    output logic             err
);

    gcd_state_t       state_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] result_q;

    logic             load, sub_a, sub_b, finish;
    logic             gt, lt, eq, a_zero, b_zero;
    logic [WIDTH-1:0] a_cur, b_cur;

    // Termination has priority over either subtraction.
    assign finish = eq | a_zero | b_zero;
    assign load   = (state_q == IDLE) & start;
    assign sub_a  = (state_q == CALC) & ~finish & gt;
    assign sub_b  = (state_q == CALC) & ~finish & lt;

    gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .sub_a_i  (sub_a),
        .sub_b_i  (sub_b),
        .a_i      (a_in),
        .b_i      (b_in),
        .a_o      (a_cur),
        .b_o      (b_cur),
        .iter_o   (iter),
        .gt_o     (gt),
        .lt_o     (lt),
        .eq_o     (eq),
        .a_zero_o (a_zero),
        .b_zero_o (b_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) state_q <= CALC;
                end
                CALC: begin
                    if (finish) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        result_q <= a_zero ? b_cur : a_cur;
                        err_q    <= a_zero & b_zero;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule
